// File: rtl/honzales_wb_regs.sv
// Wishbone classic slave register block for the Honzales core: control register,
// live status view, and a small FIFO capturing every change of the core output.
module honzales_wb_regs #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  core_out,
  output logic        core_reset,
  output logic        core_in,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  // Handshake: a request is taken at the edge where cyc & stb & in-window is seen
  // with ack low; ack is high for exactly the following cycle and then forced low,
  // so each ack completes exactly one transfer even if stb is held or has dropped.

  logic [7:0]  off;
  logic        valid;
  logic        take;
  logic        ctrl_wr;
  logic        pop;
  logic        push;
  logic        enq;
  logic        drop;
  logic [31:0] rdata;

  logic        cap_en;
  logic        soft_rst;
  logic        drive;
  logic        irq_en;
  logic        overflow;
  logic [7:0]  last;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          empty;
  logic          full;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:5]};

  assign off     = wbs_adr_i[7:0];
  assign valid   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign take    = valid & ~wbs_ack_o;
  assign ctrl_wr = take & wbs_we_i & (off == 8'h00) & wbs_sel_i[0];

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = take & ~wbs_we_i & (off == 8'h08) & ~empty;
  assign push  = cap_en & (core_out != last);
  // A pop in the same edge frees a slot, so a push into a full FIFO still lands.
  assign enq   = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign core_reset = wb_rst_i | soft_rst;
  assign core_in    = drive;
  assign irq        = irq_en & ~empty;

  always_comb begin
    rdata = '0;
    case (off)
      8'h00: rdata[3:0] = {irq_en, drive, soft_rst, cap_en};
      8'h04: begin
        rdata[7:0]  = core_out;
        rdata[10:8] = 3'(count);
        rdata[11]   = empty;
        rdata[12]   = full;
        rdata[13]   = overflow;
      end
      8'h08: begin
        if (!empty) begin
          rdata[7:0] = mem[rd_ptr];
          rdata[8]   = 1'b1;
        end
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      cap_en    <= 1'b0;
      soft_rst  <= 1'b0;
      drive     <= 1'b0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      last      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      wbs_ack_o <= take;
      wbs_dat_o <= take ? rdata : '0;
      last      <= core_out;

      if (ctrl_wr) begin
        cap_en   <= wbs_dat_i[0];
        soft_rst <= wbs_dat_i[1];
        drive    <= wbs_dat_i[2];
        irq_en   <= wbs_dat_i[3];
      end

      // A fresh drop wins over a clear issued at the same edge.
      if (drop)
        overflow <= 1'b1;
      else if (ctrl_wr && wbs_dat_i[4])
        overflow <= 1'b0;

      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({enq, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (enq) mem[wr_ptr] <= core_out;
  end

endmodule

// File: tb/tb_honzales_wb_regs.sv
// Self-checking bench for honzales_wb_regs: bus transfers with a read-data
// scoreboard, change capture, FIFO boundaries, window decode and reset abort.
module tb_honzales_wb_regs;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  core_out;
  logic        core_reset;
  logic        core_in;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  // Reference model of the block's architectural state.
  logic [7:0] m_fifo[$];
  logic [3:0] m_ctrl;
  logic       m_ovf;
  logic [7:0] m_last;

  localparam logic [31:0] BASE = 32'h3000_0000;

  honzales_wb_regs dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .core_out   (core_out),
    .core_reset (core_reset),
    .core_in    (core_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp(input logic [7:0] c, input int n, input logic ovf);
    logic [31:0] s;
    s        = '0;
    s[7:0]   = c;
    s[10:8]  = 3'(n);
    s[11]    = (n == 0);
    s[12]    = (n == 4);
    s[13]    = ovf;
    return s;
  endfunction

  task automatic model_core(input logic [7:0] v);
    if (m_ctrl[0] && v != m_last) begin
      if (m_fifo.size() < 4) m_fifo.push_back(v);
      else m_ovf = 1'b1;
    end
    m_last = v;
  endtask

  task automatic set_core(input logic [7:0] v);
    @(negedge clk);
    core_out = v;
    model_core(v);
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] e);
    e = '0;
    case (a[7:0])
      8'h00: e = {28'b0, m_ctrl};
      8'h04: e = status_exp(core_out, m_fifo.size(), m_ovf);
      8'h08: if (m_fifo.size() > 0) e = {23'b0, 1'b1, m_fifo.pop_front()};
      default: e = '0;
    endcase
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic chg, input logic [7:0] cval,
                         output logic [31:0] data, output logic acked, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    if (chg) begin
      core_out = cval;
      model_core(cval);
    end
    acked = 1'b0; lat = 0; data = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!acked && ack) begin
        acked = 1'b1;
        lat   = i;
        data  = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end
      if (acked) i = 9;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [31:0] data;
    logic        acked;
    int          lat;
    wb_xfer(1'b1, a, d, s, 1'b0, 8'h00, data, acked, lat);
    if (a[31:8] == BASE[31:8]) begin
      check_eq({tag, "_ack"}, 32'(acked), 32'd1);
      if (acked) check_eq({tag, "_lat"}, 32'(lat), 32'd1);
      if (a[7:0] == 8'h00 && s[0]) begin
        m_ctrl = d[3:0];
        if (d[4]) m_ovf = 1'b0;
      end
    end else begin
      check_eq({tag, "_noack"}, 32'(acked), 32'd0);
    end
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a, input logic chg,
                         input logic [7:0] cval);
    logic [31:0] e;
    logic [31:0] data;
    logic        acked;
    int          lat;
    model_read(a, e);
    exp_q.push_back(e);
    wb_xfer(1'b0, a, 32'h0, 4'hF, chg, cval, data, acked, lat);
    check_eq({tag, "_ack"}, 32'(acked), 32'd1);
    check_eq(tag, data, exp_q.pop_front());
  endtask

  initial begin
    logic [3:0] pat;
    logic       seen;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    core_out = 8'h00;
    m_ctrl = '0; m_ovf = 1'b0; m_last = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_dat", rdat, 32'h0);
    check_eq("rst_core_reset", 32'(core_reset), 32'd1);
    check_eq("rst_core_in", 32'(core_in), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("core_reset_rel", 32'(core_reset), 32'd0);

    // Control register write/read and byte-enable gating.
    wb_write("ctrl_wr", BASE + 32'h00, 32'h0000_000D, 4'hF);
    check_eq("core_in_on", 32'(core_in), 32'd1);
    check_eq("core_reset_soft0", 32'(core_reset), 32'd0);
    wb_read("ctrl_rd", BASE + 32'h00, 1'b0, 8'h00);
    wb_write("ctrl_sel0", BASE + 32'h00, 32'h0000_0000, 4'h0);
    wb_read("ctrl_rd_sel0", BASE + 32'h00, 1'b0, 8'h00);

    // Two captured changes, then drain past empty.
    set_core(8'h11);
    set_core(8'h22);
    @(negedge clk);
    check_eq("irq_two", 32'(irq), 32'd1);
    wb_read("stat_two", BASE + 32'h04, 1'b0, 8'h00);
    wb_read("fifo_rd1", BASE + 32'h08, 1'b0, 8'h00);
    wb_read("fifo_rd2", BASE + 32'h08, 1'b0, 8'h00);
    check_eq("irq_drained", 32'(irq), 32'd0);
    wb_read("fifo_empty", BASE + 32'h08, 1'b0, 8'h00);

    // Six changes with no reads: fill plus overflow, then clear overflow.
    for (int i = 1; i <= 6; i++) set_core(8'h30 + 8'(i));
    wb_read("stat_full", BASE + 32'h04, 1'b0, 8'h00);
    wb_write("ctrl_clr", BASE + 32'h00, 32'h0000_001D, 4'h1);
    wb_read("stat_clr", BASE + 32'h04, 1'b0, 8'h00);
    wb_read("ctrl_clr_rd", BASE + 32'h00, 1'b0, 8'h00);

    // Pop and push at the same edge while full.
    wb_read("fifo_popush", BASE + 32'h08, 1'b1, 8'h40);
    wb_read("stat_popush", BASE + 32'h04, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) wb_read("fifo_drain", BASE + 32'h08, 1'b0, 8'h00);
    wb_read("fifo_drain_empty", BASE + 32'h08, 1'b0, 8'h00);

    // Held strobe: one transfer per ack, ack every other cycle.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    check_eq("ack_pattern", 32'(pat), 32'hA);

    // Window decode and unmapped offsets.
    wb_write("oow_wr", 32'h3000_1000, 32'h0, 4'hF);
    wb_read("ctrl_after_oow", BASE + 32'h00, 1'b0, 8'h00);
    wb_read("unmapped_rd", BASE + 32'h40, 1'b0, 8'h00);
    wb_write("unmapped_wr", BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
    wb_write("status_wr", BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
    wb_read("ctrl_after_ro", BASE + 32'h00, 1'b0, 8'h00);

    // Reset landing on the request edge aborts the transfer.
    set_core(8'h55);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    rst = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    check_eq("rst_mid_core_reset", 32'(core_reset), 32'd1);
    seen = ack;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | ack;
    end
    check_eq("rst_mid_noack", 32'(seen), 32'd0);
    check_eq("rst_mid_irq", 32'(irq), 32'd0);
    check_eq("rst_mid_core_in", 32'(core_in), 32'd0);
    rst = 1'b0;
    m_fifo.delete(); m_ctrl = '0; m_ovf = 1'b0; m_last = core_out;
    @(negedge clk);
    check_eq("post_rst_core_reset", 32'(core_reset), 32'd0);
    wb_read("post_rst_ctrl", BASE + 32'h00, 1'b0, 8'h00);
    wb_read("post_rst_stat", BASE + 32'h04, 1'b0, 8'h00);
    wb_read("post_rst_fifo", BASE + 32'h08, 1'b0, 8'h00);

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
